// File: rtl/pulse_width_pkg.sv
// -----------------------------------------------------------------------------
// pulse_width_pkg
// Shared helpers for the pulse width detector:
//   cnt_width(max_w)        - width of the per-channel run counter and of
//                             last_width; it must hold MAX_W+1 (the saturated
//                             "over-long" value).
//   params_ok(min_w, max_w) - legality of the width window, evaluated at
//                             elaboration time by the top level.
// No ports (package).
// -----------------------------------------------------------------------------
package pulse_width_pkg;

  function automatic int cnt_width(input int max_w);
    return $clog2(max_w + 2);
  endfunction

  function automatic bit params_ok(input int min_w, input int max_w);
    return (min_w >= 1) && (max_w >= min_w);
  endfunction

endpackage

// File: rtl/pulse_width_channel.sv
// -----------------------------------------------------------------------------
// pulse_width_channel
// One independent channel of the pulse width detector. Flags the edges of the
// active level, counts the length of each active run and classifies a
// completed run as in-window (pulse_ok) or over-long (pulse_long).
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   a          in   sampled input bit, synchronous to clk
//   rise       out  idle->active edge this cycle (combinational)
//   fall       out  active->idle edge this cycle (combinational)
//   pulse_ok   out  completed run width within [MIN_W, MAX_W] (combinational)
//   pulse_long out  current run just exceeded MAX_W (combinational)
//   last_width out  width of the last completed run, saturated at MAX_W+1
//                   (registered, updated the cycle after fall)
// -----------------------------------------------------------------------------
module pulse_width_channel
  import pulse_width_pkg::*;
#(
  parameter int   MIN_W       = 1,
  parameter int   MAX_W       = 1,
  parameter int   ACTIVE_HIGH = 1,
  localparam int  CW          = cnt_width(MAX_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  output logic          rise,
  output logic          fall,
  output logic          pulse_ok,
  output logic          pulse_long,
  output logic [CW-1:0] last_width
);

  localparam logic [CW-1:0] C_MIN = CW'(MIN_W);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_W);
  // Saturation value: one past the window, so an over-long run stays
  // distinguishable from any accepted width and the counter never wraps.
  localparam logic [CW-1:0] C_SAT = CW'(MAX_W + 1);

  logic          w_act;
  logic          w_fall;
  logic          r_act;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_lw;

  // Low-active lines are inverted here so the rest of the channel only ever
  // deals with "active" runs; the idle level then maps to r_act = 0.
  assign w_act  = (ACTIVE_HIGH != 0) ? a : ~a;
  assign w_fall = ~w_act & r_act;

  assign rise       = w_act & ~r_act;
  assign fall       = w_fall;
  // r_cnt still holds the finished run length during the fall cycle.
  assign pulse_ok   = w_fall & (r_cnt >= C_MIN) & (r_cnt <= C_MAX);
  // r_cnt reaches MAX_W exactly once per run, so this fires once, on the
  // (MAX_W+1)th active sample.
  assign pulse_long = w_act & (r_cnt == C_MAX);
  assign last_width = r_lw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act <= 1'b0;
      r_cnt <= '0;
      r_lw  <= '0;
    end else begin
      r_act <= w_act;
      if (!w_act) begin
        r_cnt <= '0;
      end else if (!r_act) begin
        r_cnt <= CW'(1);
      end else if (r_cnt != C_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fall) begin
        r_lw <= r_cnt;
      end
    end
  end

endmodule

// File: rtl/pulse_width_detector.sv
// -----------------------------------------------------------------------------
// pulse_width_detector
// Multi-channel pulse edge / width detector for synchronised control and
// strobe lines. Each channel is an independent pulse_width_channel; with the
// default MIN_W = MAX_W = 1, pulse_ok reproduces a one-cycle (010) detector.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   a          in   [N_CH]     sampled inputs, one bit per channel
//   rise       out  [N_CH]     idle->active edge (combinational)
//   fall       out  [N_CH]     active->idle edge (combinational)
//   pulse_ok   out  [N_CH]     completed pulse width in [MIN_W, MAX_W]
//   pulse_long out  [N_CH]     current run just exceeded MAX_W
//   last_width out  [N_CH*CW]  last completed width per channel, channel i at
//                              bits [i*CW +: CW], registered
// -----------------------------------------------------------------------------
module pulse_width_detector
  import pulse_width_pkg::*;
#(
  parameter int  N_CH        = 4,
  parameter int  MIN_W       = 1,
  parameter int  MAX_W       = 1,
  parameter int  ACTIVE_HIGH = 1,
  localparam int CW          = cnt_width(MAX_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    a,
  output logic [N_CH-1:0]    rise,
  output logic [N_CH-1:0]    fall,
  output logic [N_CH-1:0]    pulse_ok,
  output logic [N_CH-1:0]    pulse_long,
  output logic [N_CH*CW-1:0] last_width
);

  if (!params_ok(MIN_W, MAX_W)) begin : g_param_err
    $error("pulse_width_detector: need MIN_W >= 1 and MAX_W >= MIN_W");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_width_channel #(
      .MIN_W      (MIN_W),
      .MAX_W      (MAX_W),
      .ACTIVE_HIGH(ACTIVE_HIGH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .a         (a[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .pulse_ok  (pulse_ok[i]),
      .pulse_long(pulse_long[i]),
      .last_width(last_width[i*CW +: CW])
    );
  end

endmodule

// File: tb/tb_pulse_width_detector.sv
// -----------------------------------------------------------------------------
// tb_pulse_width_detector
// Four detector instances with different parameter sets share clk/rst:
//   d0: MIN_W=1 MAX_W=1 active high   (CW=2)
//   d1: MIN_W=2 MAX_W=3 active high   (CW=3)
//   d2: MIN_W=1 MAX_W=1 active low    (CW=2)
//   d3: MIN_W=1 MAX_W=2 active high   (CW=2)
// Every cycle all outputs are compared with a run-length model; directed
// scenarios add fixed expected values on top.
// -----------------------------------------------------------------------------
module tb_pulse_width_detector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  a_d    [4];
  logic [3:0]  rise_d [4];
  logic [3:0]  fall_d [4];
  logic [3:0]  ok_d   [4];
  logic [3:0]  long_d [4];
  logic [7:0]  lw0, lw2, lw3;
  logic [11:0] lw1;

  pulse_width_detector #(.N_CH(4), .MIN_W(1), .MAX_W(1), .ACTIVE_HIGH(1)) u_d0 (
    .clk(clk), .rst(rst), .a(a_d[0]), .rise(rise_d[0]), .fall(fall_d[0]),
    .pulse_ok(ok_d[0]), .pulse_long(long_d[0]), .last_width(lw0));
  pulse_width_detector #(.N_CH(4), .MIN_W(2), .MAX_W(3), .ACTIVE_HIGH(1)) u_d1 (
    .clk(clk), .rst(rst), .a(a_d[1]), .rise(rise_d[1]), .fall(fall_d[1]),
    .pulse_ok(ok_d[1]), .pulse_long(long_d[1]), .last_width(lw1));
  pulse_width_detector #(.N_CH(4), .MIN_W(1), .MAX_W(1), .ACTIVE_HIGH(0)) u_d2 (
    .clk(clk), .rst(rst), .a(a_d[2]), .rise(rise_d[2]), .fall(fall_d[2]),
    .pulse_ok(ok_d[2]), .pulse_long(long_d[2]), .last_width(lw2));
  pulse_width_detector #(.N_CH(4), .MIN_W(1), .MAX_W(2), .ACTIVE_HIGH(1)) u_d3 (
    .clk(clk), .rst(rst), .a(a_d[3]), .rise(rise_d[3]), .fall(fall_d[3]),
    .pulse_ok(ok_d[3]), .pulse_long(long_d[3]), .last_width(lw3));

  int P_MIN [4] = '{1, 2, 1, 1};
  int P_MAX [4] = '{1, 3, 1, 2};
  bit P_AH  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  // Reference model: length of the current active run (unbounded), previous
  // activity, and last finished width clipped to MAX_W+1.
  int m_run  [4][4];
  bit m_prev [4][4];
  int m_lw   [4][4];

  // Outputs captured at the last check point, for directed checks.
  bit o_rise [4][4];
  bit o_fall [4][4];
  bit o_ok   [4][4];
  bit o_long [4][4];
  int o_lw   [4][4];

  int n_pass  = 0;
  int n_total = 0;
  int step_no = 0;

  function automatic int get_lw(input int d, input int ch);
    case (d)
      0:       return int'(lw0[ch*2 +: 2]);
      1:       return int'(lw1[ch*3 +: 3]);
      2:       return int'(lw2[ch*2 +: 2]);
      default: return int'(lw3[ch*2 +: 2]);
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++)
      for (int ch = 0; ch < 4; ch++) begin
        m_run[d][ch]  = 0;
        m_prev[d][ch] = 1'b0;
        m_lw[d][ch]   = 0;
      end
  endtask

  // One clock cycle: drive inputs, check every output against the model
  // away from the edge, then advance the model over the rising edge.
  task automatic step(input bit r, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [3:0] a2, input logic [3:0] a3);
    bit act, e_rise, e_fall, e_ok, e_long;
    rst = r;
    a_d[0] = a0; a_d[1] = a1; a_d[2] = a2; a_d[3] = a3;
    if (r) model_reset();
    @(negedge clk);
    for (int d = 0; d < 4; d++)
      for (int ch = 0; ch < 4; ch++) begin
        act    = P_AH[d] ? a_d[d][ch] : ~a_d[d][ch];
        e_rise = act && !m_prev[d][ch];
        e_fall = !act && m_prev[d][ch];
        e_ok   = e_fall && (m_run[d][ch] >= P_MIN[d]) && (m_run[d][ch] <= P_MAX[d]);
        e_long = act && (m_run[d][ch] == P_MAX[d]);
        o_rise[d][ch] = rise_d[d][ch];
        o_fall[d][ch] = fall_d[d][ch];
        o_ok[d][ch]   = ok_d[d][ch];
        o_long[d][ch] = long_d[d][ch];
        o_lw[d][ch]   = get_lw(d, ch);
        chk($sformatf("d%0d.ch%0d.rise@%0d", d, ch, step_no), int'(o_rise[d][ch]), int'(e_rise));
        chk($sformatf("d%0d.ch%0d.fall@%0d", d, ch, step_no), int'(o_fall[d][ch]), int'(e_fall));
        chk($sformatf("d%0d.ch%0d.ok@%0d", d, ch, step_no), int'(o_ok[d][ch]), int'(e_ok));
        chk($sformatf("d%0d.ch%0d.long@%0d", d, ch, step_no), int'(o_long[d][ch]), int'(e_long));
        chk($sformatf("d%0d.ch%0d.lw@%0d", d, ch, step_no), o_lw[d][ch], m_lw[d][ch]);
      end
    @(posedge clk);
    #1;
    if (!r) begin
      for (int d = 0; d < 4; d++)
        for (int ch = 0; ch < 4; ch++) begin
          act = P_AH[d] ? a_d[d][ch] : ~a_d[d][ch];
          if (!act && m_prev[d][ch])
            m_lw[d][ch] = (m_run[d][ch] > P_MAX[d] + 1) ? P_MAX[d] + 1 : m_run[d][ch];
          m_run[d][ch]  = act ? m_run[d][ch] + 1 : 0;
          m_prev[d][ch] = act;
        end
    end
    step_no++;
  endtask

  initial begin
    logic [15:0] seq1, e1_rise, e1_fall, e1_ok, e1_long;
    logic [3:0]  cur [4];
    bit          b, b2;
    int          n_long, long_at, quiet;

    seq1    = 16'b1001011011110001;
    e1_rise = 16'b1001010010000001;
    e1_fall = 16'b0100100100001000;
    e1_ok   = 16'b0100100000000000;
    e1_long = 16'b0000001001000000;

    rst = 1'b1;
    a_d[0] = 4'h0; a_d[1] = 4'h0; a_d[2] = 4'hF; a_d[3] = 4'h0;
    model_reset();

    // Reset with idle inputs: everything quiet and zero.
    step(1'b1, 4'h0, 4'h0, 4'hF, 4'h0);
    step(1'b1, 4'h0, 4'h0, 4'hF, 4'h0);
    chk("reset.lw_d1", o_lw[1][0], 0);
    chk("reset.rise_d0", int'(o_rise[0][0]), 0);

    // Plan 1/2 on d0/d1 ch0, plan 3 on d2 ch0, plan 5 on d3, in parallel.
    for (int i = 0; i < 16; i++) begin
      b  = seq1[15-i];
      b2 = (i == 1) ? 1'b0 : 1'b1;
      step(1'b0, {3'b000, b}, {3'b000, b}, {3'b111, b2},
           {1'b0, (i >= 1 && i <= 3), (i >= 1 && i <= 2), (i == 1)});
      chk($sformatf("t1.rise[%0d]", i), int'(o_rise[0][0]), int'(e1_rise[15-i]));
      chk($sformatf("t1.fall[%0d]", i), int'(o_fall[0][0]), int'(e1_fall[15-i]));
      chk($sformatf("t1.ok[%0d]", i),   int'(o_ok[0][0]),   int'(e1_ok[15-i]));
      chk($sformatf("t1.long[%0d]", i), int'(o_long[0][0]), int'(e1_long[15-i]));
      quiet = 0;
      for (int ch = 1; ch < 4; ch++)
        quiet += int'(o_rise[0][ch]) + int'(o_fall[0][ch]) + int'(o_ok[0][ch]) + int'(o_long[0][ch]);
      chk($sformatf("t1.quiet[%0d]", i), quiet, 0);
      chk($sformatf("t2.ok[%0d]", i),   int'(o_ok[1][0]),   int'(i == 7));
      chk($sformatf("t2.long[%0d]", i), int'(o_long[1][0]), int'(i == 11));
      case (i)
        2:  begin chk("t1.lw1", o_lw[0][0], 1); chk("t2.lw1", o_lw[1][0], 1); end
        5:  begin chk("t1.lw2", o_lw[0][0], 1); chk("t2.lw2", o_lw[1][0], 1); end
        8:  begin chk("t1.lw3", o_lw[0][0], 2); chk("t2.lw3", o_lw[1][0], 2); end
        13: begin chk("t1.lw4", o_lw[0][0], 2); chk("t2.lw4", o_lw[1][0], 4); end
        default: ;
      endcase
      chk($sformatf("t3.rise[%0d]", i), int'(o_rise[2][0]), int'(i == 1));
      chk($sformatf("t3.fall[%0d]", i), int'(o_fall[2][0]), int'(i == 2));
      chk($sformatf("t3.ok[%0d]", i),   int'(o_ok[2][0]),   int'(i == 2));
      chk($sformatf("t5.ok0[%0d]", i),  int'(o_ok[3][0]),   int'(i == 2));
      chk($sformatf("t5.ok1[%0d]", i),  int'(o_ok[3][1]),   int'(i == 3));
      chk($sformatf("t5.ok2[%0d]", i),  int'(o_ok[3][2]),   0);
      chk($sformatf("t5.long0[%0d]", i), int'(o_long[3][0]), 0);
      chk($sformatf("t5.long1[%0d]", i), int'(o_long[3][1]), 0);
      chk($sformatf("t5.long2[%0d]", i), int'(o_long[3][2]), int'(i == 3));
    end

    // Plan 4: reset in the middle of a pulse on ch0 of d0/d1.
    step(1'b0, 4'h0, 4'h0, 4'hF, 4'h0);
    step(1'b0, 4'h0, 4'h0, 4'hF, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h1, 4'h1, 4'hF, 4'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'h1, 4'h1, 4'hF, 4'h0);
      chk($sformatf("t4.nofall_rst%0d", i), int'(o_fall[1][0]), 0);
      chk($sformatf("t4.lw_rst%0d", i), o_lw[1][0], 0);
    end
    step(1'b0, 4'h1, 4'h1, 4'hF, 4'h0);
    chk("t4.rise_after", int'(o_rise[1][0]), 1);
    chk("t4.nofall_after", int'(o_fall[1][0]), 0);
    step(1'b0, 4'h1, 4'h1, 4'hF, 4'h0);
    step(1'b0, 4'h0, 4'h0, 4'hF, 4'h0);
    chk("t4.fall", int'(o_fall[1][0]), 1);
    chk("t4.ok", int'(o_ok[1][0]), 1);
    step(1'b0, 4'h0, 4'h0, 4'hF, 4'h0);
    chk("t4.lw", o_lw[1][0], 2);

    // Plan 6: 20-cycle run on d1 ch0 (MAX_W=3).
    n_long  = 0;
    long_at = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'h0, 4'h1, 4'hF, 4'h0);
      if (o_long[1][0]) begin
        n_long++;
        long_at = i;
      end
    end
    chk("t6.long_count", n_long, 1);
    chk("t6.long_at", long_at, 3);
    step(1'b0, 4'h0, 4'h0, 4'hF, 4'h0);
    chk("t6.fall", int'(o_fall[1][0]), 1);
    chk("t6.ok", int'(o_ok[1][0]), 0);
    step(1'b0, 4'h0, 4'h0, 4'hF, 4'h0);
    chk("t6.lw_sat", o_lw[1][0], 4);

    // Random runs on every channel of every instance, with occasional resets.
    cur[0] = 4'h0; cur[1] = 4'h0; cur[2] = 4'hF; cur[3] = 4'h0;
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 4; d++)
        for (int ch = 0; ch < 4; ch++)
          if ($urandom_range(3) == 0) cur[d][ch] = ~cur[d][ch];
      step(($urandom_range(63) == 0), cur[0], cur[1], cur[2], cur[3]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_width_detector.md
Name: pulse_width_detector

Overview:
- Multi-channel, parametrised successor of the single-bit posedge / one-cycle-pulse (010) detectors.
- Per channel, on a synchronous single-bit input: flags rising and falling edges, measures the length of each active run, and classifies a completed pulse as in-window or over-long.
- Sits directly behind synchronisers on control/strobe lines; downstream logic consumes the one-cycle flags.
- With default parameters, pulse_ok on each channel is identical to the 010 detector.

Parameters:
- N_CH, 4: number of independent channels.
- MIN_W, 1: minimum accepted pulse width in clk cycles; must be ≥ 1.
- MAX_W, 1: maximum accepted pulse width in clk cycles; must be ≥ MIN_W.
- ACTIVE_HIGH, 1: 1 = pulses are high runs; 0 = pulses are low runs (input inverted internally, idle level = 1).
- CW (localparam): $clog2(MAX_W+2), the width of the run counter and last_width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- a, in, N_CH: sampled inputs, one bit per channel, synchronous to clk.
- rise, out, N_CH: idle→active edge on a[i] this cycle (combinational).
- fall, out, N_CH: active→idle edge on a[i] this cycle (combinational).
- pulse_ok, out, N_CH: completed pulse width in [MIN_W, MAX_W] (combinational).
- pulse_long, out, N_CH: current run has just exceeded MAX_W (combinational).
- last_width, out, N_CH*CW: registered width of the last completed pulse per channel; channel i occupies bits [i*CW +: CW].

Behaviour:
- Per channel state:
  - act_r: previous active sample, 1 bit.
  - cnt: consecutive active samples up to and including the previous cycle, CW bits.
  - lw: last completed width, CW bits.
- act = ACTIVE_HIGH ? a[i] : ~a[i].
- Reset: act_r=0 (idle), cnt=0, lw=0. All outputs are 0 while rst is high, provided a is at idle level.
- Reset mid-pulse:
  - Any in-progress run is discarded; no fall or pulse_ok is generated for it.
  - If a is active when rst deasserts, rise=1 in the first cycle after reset, and counting starts there (same as the posedge detector).
- Combinational outputs, same cycle as the current sample:
  - rise = act & ~act_r.
  - fall = ~act & act_r.
  - pulse_ok = fall & (cnt >= MIN_W) & (cnt <= MAX_W).
  - pulse_long = act & (cnt == MAX_W). This fires exactly once per run, on the (MAX_W+1)th active sample.
- Sequential update each posedge clk:
  - act_r <= act.
  - If act and ~act_r: cnt <= 1.
  - If act and act_r: cnt <= (cnt == MAX_W+1) ? cnt : cnt+1. This saturates and never wraps.
  - If ~act: cnt <= 0.
  - If fall: lw <= cnt. The updated last_width is visible the cycle after fall.
- Latency: edge and classification flags have zero cycles of latency from the sample; last_width has 1 cycle.
- An over-long pulse gives pulse_long mid-run, then fall with pulse_ok=0, and last_width = MAX_W+1 (saturated).
- Back-to-back pulses separated by a single idle cycle are each classified independently.
- Channels are fully independent; there is no shared state.

Decomposition:
- Package pulse_width_pkg:
  - function cnt_width(max_w), returning $clog2(max_w+2).
  - Elaboration-time parameter check: MIN_W ≥ 1 and MAX_W ≥ MIN_W.
- Sub-module pulse_width_channel:
  - Parameters MIN_W, MAX_W, ACTIVE_HIGH.
  - Single-bit input; rise/fall/pulse_ok/pulse_long and last_width outputs.
  - Instantiated N_CH times in a generate loop.

Test Plan:
1. Defaults, channel 0 driven with a = 1001011011110001, other channels 0, expected values sampled per cycle:
   - rise = 1001010010000001
   - fall = 0100100100001000
   - pulse_ok = 0100100000000000
   - pulse_long = 0000001001000000
   - last_width after each fall = 1, 1, 2, 2 (saturated).
   - Channels 1–3 stay 0 throughout.
2. MIN_W=2, MAX_W=3, same sequence on channel 0:
   - pulse_ok only at index 7.
   - pulse_long only at index 11.
   - last_width = 1, 1, 2, 4 after the respective falls.
3. ACTIVE_HIGH=0, defaults, a = 1011: pulse_ok=1 at index 2; rise=1 at index 1; fall=1 at index 2.
4. Reset mid-pulse: drive a=1 for 3 cycles, assert rst for 2 cycles, keep a=1, then drive a=0:
   - rise=1 in the first cycle after reset.
   - On the eventual fall, last_width counts only post-reset samples.
   - No spurious fall during or just after reset.
5. Independent channels: simultaneously drive ch0 = 010, ch1 = 0110, ch2 = 01110, ch3 = 0 with MIN_W=1, MAX_W=2:
   - pulse_ok asserted for ch0 and ch1 only, each at its own fall cycle.
   - pulse_long asserted for ch2 only, at its 3rd high sample.
6. Long run saturation: MAX_W=3, a high for 20 cycles then low:
   - pulse_long exactly once, at the 4th high sample.
   - cnt does not wrap.
   - last_width = 4; pulse_ok=0.
